// File: rtl/accum_pkg.sv
// Shared definitions for the accumulate stage: FSM state encoding and the
// saturation constant helper used for the beat counter.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // All-ones value of a counter that is w bits wide (w <= 32).
  function automatic logic [31:0] cnt_sat_max(input int w);
    logic [32:0] one_hot;
    one_hot = 33'd1 << w;
    return 32'(one_hot - 33'd1);
  endfunction

endpackage

// File: rtl/accum_result_reg.sv
// Result holding register for the accumulate stage. Captures a committed
// packet result, raises valid, and keeps the payload stable until the
// downstream side takes it. clear drops valid but leaves the payload.
module accum_result_reg
  import accum_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [N-1:0]     sum_i,
  input  logic             cout_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [N-1:0]     sum_o,
  output logic             cout_o,
  output logic [CNT_W-1:0] count_o
);

  logic             valid_q, valid_d;
  logic [N-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state: clear wins, then a new commit, then a completed handshake.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    count_d = count_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      sum_d   = sum_i;
      cout_d  = cout_i;
      count_d = count_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output registers, zeroed by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      count_q <= count_d;
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign count_o = count_q;

endmodule

// File: rtl/accum_stage.sv
// Packet accumulate stage: sums the operand beats of a packet, tracks a
// sticky carry and a saturating beat count, and presents the result through
// a valid/ready holding register. Input is stalled while a result is held.
// Optional build macro: ACCUM_SATURATE_EN clamps the sum to all-ones on the
// first carry instead of wrapping.
module accum_stage
  import accum_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_cout,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_max(CNT_W));

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N:0]       sum_ext_s;
  logic             accept_s;
  logic             commit_s;

  assign in_ready = (state_q != HOLD);
  assign accept_s = in_valid && in_ready;

  // Datapath and state transitions; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    count_d   = count_q;
    commit_s  = 1'b0;
    sum_ext_s = {1'b0, acc_q} + {1'b0, in_data};
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      carry_d = 1'b0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept_s) begin
            if (state_q == IDLE) begin
              acc_d   = in_data;
              carry_d = 1'b0;
              count_d = CNT_W'(1);
            end else begin
`ifdef ACCUM_SATURATE_EN
              if (sum_ext_s[N] || carry_q) begin
                acc_d = {N{1'b1}};
              end else begin
                acc_d = sum_ext_s[N-1:0];
              end
`else
              acc_d = sum_ext_s[N-1:0];
`endif
              carry_d = carry_q | sum_ext_s[N];
              count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
            end
            if (in_last) begin
              state_d  = HOLD;
              commit_s = 1'b1;
            end else begin
              state_d = ACCUM;
            end
          end else begin
            state_d = state_q;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

  accum_result_reg #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_result (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .load_i  (commit_s),
    .sum_i   (acc_d),
    .cout_i  (carry_d),
    .count_i (count_d),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .sum_o   (out_sum),
    .cout_o  (out_cout),
    .count_o (out_count)
  );

endmodule

// File: tb/tb_accum_stage.sv
// Directed, table-driven bench for accum_stage (N=8, CNT_W=8).
module tb_accum_stage;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_cout;
  logic [7:0] out_count;

  int n_checks;
  int n_fail;

  accum_stage #(.N(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] beats;
    int              n;
    logic [7:0]      exp_sum;
    logic            exp_cout;
    logic [7:0]      exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] s, input logic c, input logic [7:0] k);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".sum"},   {24'd0, out_sum},   {24'd0, s});
    chk({tag, ".cout"},  {31'd0, out_cout},  {31'd0, c});
    chk({tag, ".count"}, {24'd0, out_count}, {24'd0, k});
    chk({tag, ".in_ready_hold"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".valid_after_take"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready_after_take"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{beats: {8'h00, 8'h05, 8'h20, 8'h10}, n: 3, exp_sum: 8'h35, exp_cout: 1'b0, exp_cnt: 8'd3};
`ifdef ACCUM_SATURATE_EN
    vecs[1] = '{beats: {8'h00, 8'h00, 8'h20, 8'hF0}, n: 2, exp_sum: 8'hFF, exp_cout: 1'b1, exp_cnt: 8'd2};
    vecs[3] = '{beats: {8'h00, 8'h01, 8'h80, 8'h80}, n: 3, exp_sum: 8'hFF, exp_cout: 1'b1, exp_cnt: 8'd3};
    vecs[5] = '{beats: {8'h01, 8'h7F, 8'h01, 8'h7F}, n: 4, exp_sum: 8'hFF, exp_cout: 1'b1, exp_cnt: 8'd4};
`else
    vecs[1] = '{beats: {8'h00, 8'h00, 8'h20, 8'hF0}, n: 2, exp_sum: 8'h10, exp_cout: 1'b1, exp_cnt: 8'd2};
    vecs[3] = '{beats: {8'h00, 8'h01, 8'h80, 8'h80}, n: 3, exp_sum: 8'h01, exp_cout: 1'b1, exp_cnt: 8'd3};
    vecs[5] = '{beats: {8'h01, 8'h7F, 8'h01, 8'h7F}, n: 4, exp_sum: 8'h00, exp_cout: 1'b1, exp_cnt: 8'd4};
`endif
    vecs[2] = '{beats: {8'h00, 8'h00, 8'h00, 8'hAB}, n: 1, exp_sum: 8'hAB, exp_cout: 1'b0, exp_cnt: 8'd1};
    vecs[4] = '{beats: {8'h00, 8'h00, 8'h00, 8'hFF}, n: 4, exp_sum: 8'hFF, exp_cout: 1'b0, exp_cnt: 8'd4};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.sum",   {24'd0, out_sum},   32'd0);
    chk("rst.cout",  {31'd0, out_cout},  32'd0);
    chk("rst.count", {24'd0, out_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven packets
    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vecs[v].n; b++) begin
        send_beat(vecs[v].beats[b], (b == vecs[v].n - 1));
        if (b != vecs[v].n - 1)
          chk($sformatf("vec%0d.beat%0d.no_valid", v, b), {31'd0, out_valid}, 32'd0);
      end
      check_result($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cout, vecs[v].exp_cnt);
      take_result($sformatf("vec%0d", v));
    end

    // Held result with out_ready low and input pressure: nothing consumed
    send_beat(8'h10, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_result($sformatf("hold%0d", i), 8'h10, 1'b0, 8'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold.release.valid", {31'd0, out_valid}, 32'd0);
    chk("hold.release.in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    send_beat(8'h07, 1'b1);
    check_result("after_hold", 8'h07, 1'b0, 8'd1);
    take_result("after_hold");

    // clear mid-packet, with a competing last beat in the same cycle
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_last  = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("clear_mid.valid", {31'd0, out_valid}, 32'd0);
    chk("clear_mid.in_ready", {31'd0, in_ready}, 32'd1);
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b1);
    check_result("after_clear", 8'h03, 1'b0, 8'd2);

    // clear while holding a result
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear_hold.valid", {31'd0, out_valid}, 32'd0);
    chk("clear_hold.in_ready", {31'd0, in_ready}, 32'd1);

    // Count saturation: 300 beats of 0x01
    for (int i = 0; i < 299; i++) send_beat(8'h01, 1'b0);
    send_beat(8'h01, 1'b1);
`ifdef ACCUM_SATURATE_EN
    check_result("sat_count", 8'hFF, 1'b1, 8'hFF);
`else
    check_result("sat_count", 8'h2C, 1'b1, 8'hFF);
`endif

    // Asynchronous reset while holding
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst.valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst.sum",   {24'd0, out_sum},   32'd0);
    chk("async_rst.cout",  {31'd0, out_cout},  32'd0);
    chk("async_rst.count", {24'd0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst.valid_after", {31'd0, out_valid}, 32'd0);
    send_beat(8'h05, 1'b1);
    check_result("after_rst", 8'h05, 1'b0, 8'd1);
    take_result("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
